// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 fetch constants
package rv32_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int PC_INC = 4;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry circular skid FIFO for fetched {pc, word} pairs
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 64,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  data,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = data;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_d = next_ptr(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer: PC, in-flight tracking, redirect, skid FIFO
module fetch_ctrl #(
  parameter int XLEN = rv32_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = rv32_pkg::RESET_PC_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);
  import rv32_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0]   pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [XLEN-1:0]   inflight_pc_q, inflight_pc_d;
  logic [XLEN-1:0]   target;
  logic [2*XLEN-1:0] fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic              push, pop, issue;
  logic [CW:0]       occupancy;

  assign target     = {redirect_pc[XLEN-1:2], 2'b00};
  assign imem_addr  = redirect_valid ? target : pc_q;
  assign inst_valid = ~fifo_empty & ~redirect_valid;
  assign pop        = inst_valid & inst_ready;
  assign inst_pc    = fifo_head[2*XLEN-1:XLEN];
  assign inst_data  = fifo_head[XLEN-1:0];

  // Slots already promised (buffered + in flight) must leave room for one more word.
  assign occupancy  = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue      = fetch_en & (occupancy < (CW+1)'(DEPTH));

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    push          = 1'b0;
    if (redirect_valid) begin
      if (fetch_en) begin
        inflight_d    = 1'b1;
        inflight_pc_d = target;
        pc_d          = target + XLEN'(PC_INC);
      end else begin
        inflight_d    = 1'b0;
        pc_d          = target;
      end
    end else begin
      push       = inflight_q;
      inflight_d = issue;
      if (issue) begin
        inflight_pc_d = pc_q;
        pc_d          = pc_q + XLEN'(PC_INC);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .W(2*XLEN)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .data  ({inflight_pc_q, imem_rdata}),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl with a stream-level reference model
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int          n_cmp = 0;
  int          n_err = 0;
  logic        mon_en = 1'b0;
  logic [31:0] exp_pc = '0;
  int          delivered = 0;

  fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Synchronous-read memory: word for the address presented at an edge appears after it.
  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  // Stream model: delivered pcs run consecutively from the last redirect target or reset pc.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      n_cmp++;
      if (dut.push && dut.fifo_full) begin
        n_err++;
        $display("FAIL push_into_full: push=%0b full=%0b required no push when full", dut.push, dut.fifo_full);
      end
      if (redirect_valid) begin
        n_cmp++;
        if (inst_valid !== 1'b0) begin
          n_err++;
          $display("FAIL redirect_valid_low: inst_valid=%0b required 0", inst_valid);
        end
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (inst_valid && inst_ready) begin
        n_cmp++;
        if (inst_pc !== exp_pc || inst_data !== mem_word(exp_pc)) begin
          n_err++;
          $display("FAIL stream_order: pc=%h data=%h required pc=%h data=%h", inst_pc, inst_data, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; fetch_en = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0; mon_en = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    n_cmp++;
    if (imem_addr !== 32'h0 || inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state: addr=%h valid=%0b data=%h pc=%h required 0/0/0/0", imem_addr, inst_valid, inst_data, inst_pc);
    end
    next_cycle();
  endtask

  task automatic test_stream;
    exp_pc = 32'h0; mon_en = 1'b1;
    rst = 1'b0; fetch_en = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (imem_addr !== 32'(4*i)) begin
        n_err++;
        $display("FAIL stream_addr[%0d]: addr=%h required %h", i, imem_addr, 32'(4*i));
      end
      n_cmp++;
      if (inst_valid !== (i >= 2)) begin
        n_err++;
        $display("FAIL stream_valid[%0d]: valid=%0b required %0b", i, inst_valid, (i >= 2));
      end
      if (i >= 2) begin
        n_cmp++;
        if (inst_pc !== 32'(4*(i-2)) || inst_data !== mem_word(32'(4*(i-2)))) begin
          n_err++;
          $display("FAIL stream_pc[%0d]: pc=%h data=%h required pc=%h", i, inst_pc, inst_data, 32'(4*(i-2)));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_stall;
    logic [31:0] hold_pc, hold_addr;
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        hold_pc = inst_pc; hold_addr = imem_addr;
      end else begin
        n_cmp++;
        if (inst_valid !== 1'b1 || inst_pc !== hold_pc || imem_addr !== hold_addr) begin
          n_err++;
          $display("FAIL stall_hold[%0d]: valid=%0b pc=%h addr=%h required 1/%h/%h", i, inst_valid, inst_pc, imem_addr, hold_pc, hold_addr);
        end
      end
      if (i == 4) begin
        n_cmp++;
        if (dut.fifo_count !== 2'd2) begin
          n_err++;
          $display("FAIL stall_fill: count=%0d required 2", dut.fifo_count);
        end
      end
      next_cycle();
    end
    inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== hold_pc + 32'(4*i)) begin
        n_err++;
        $display("FAIL stall_resume[%0d]: valid=%0b pc=%h required 1/%h", i, inst_valid, inst_pc, hold_pc + 32'(4*i));
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect;
    logic [31:0] ea [4];
    logic        ev [4];
    logic [31:0] ep [4];
    ea = '{32'h20, 32'h24, 32'h28, 32'h2C};
    ev = '{1'b0, 1'b0, 1'b1, 1'b1};
    ep = '{32'h0, 32'h0, 32'h20, 32'h24};
    redirect_valid = 1'b1; redirect_pc = 32'h23;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (imem_addr !== ea[i] || inst_valid !== ev[i] || (ev[i] && inst_pc !== ep[i])) begin
        n_err++;
        $display("FAIL redirect[%0d]: addr=%h valid=%0b pc=%h required %h/%0b/%h", i, imem_addr, inst_valid, inst_pc, ea[i], ev[i], ep[i]);
      end
      next_cycle();
      redirect_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back;
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    next_cycle();
    redirect_pc = 32'h40;
    @(negedge clk);
    n_cmp++;
    if (imem_addr !== 32'h40 || inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_issue: addr=%h valid=%0b required 40/0", imem_addr, inst_valid);
    end
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_gap: valid=%0b required 0", inst_valid);
    end
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h40 + 32'(4*i)) begin
        n_err++;
        $display("FAIL b2b_pc[%0d]: valid=%0b pc=%h required 1/%h", i, inst_valid, inst_pc, 32'h40 + 32'(4*i));
      end
      next_cycle();
    end
  endtask

  task automatic test_async_reset;
    inst_ready = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    n_cmp++;
    if (dut.fifo_count !== 2'd2) begin
      n_err++;
      $display("FAIL areset_prefill: count=%0d required 2", dut.fifo_count);
    end
    @(posedge clk);
    #3;
    mon_en = 1'b0; rst = 1'b1;
    #1;
    n_cmp++;
    if (imem_addr !== 32'h0 || inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0) begin
      n_err++;
      $display("FAIL areset_outputs: addr=%h valid=%0b data=%h pc=%h required 0/0/0/0", imem_addr, inst_valid, inst_data, inst_pc);
    end
    next_cycle();
    exp_pc = 32'h0; mon_en = 1'b1; rst = 1'b0; inst_ready = 1'b1; fetch_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL areset_restart: addr=%h valid=%0b required 0/0", imem_addr, inst_valid);
    end
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
      n_err++;
      $display("FAIL areset_first: valid=%0b pc=%h required 1/0", inst_valid, inst_pc);
    end
    next_cycle();
  endtask

  task automatic test_fetch_en;
    logic [31:0] ea [10];
    logic        ev [10];
    logic [31:0] ep [10];
    logic        fe [10];
    ea = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'hC, 32'h10, 32'h14};
    ev = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    ep = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h0, 32'h0, 32'h8, 32'hC};
    fe = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      redirect_valid = (i == 0);
      redirect_pc    = 32'hFFFF_FFF8;
      fetch_en       = fe[i];
      @(negedge clk);
      n_cmp++;
      if (imem_addr !== ea[i] || inst_valid !== ev[i] || (ev[i] && inst_pc !== ep[i])) begin
        n_err++;
        $display("FAIL fetch_en[%0d]: addr=%h valid=%0b pc=%h required %h/%0b/%h", i, imem_addr, inst_valid, inst_pc, ea[i], ev[i], ep[i]);
      end
      next_cycle();
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_random;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_pc = '0, prev_data = '0;
    int          start = delivered;
    for (int c = 0; c < 800; c++) begin
      fetch_en       = ($urandom_range(0, 9) < 8);
      inst_ready     = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      @(negedge clk);
      if (prev_hold && !redirect_valid) begin
        n_cmp++;
        if (inst_valid !== 1'b1 || inst_pc !== prev_pc || inst_data !== prev_data) begin
          n_err++;
          $display("FAIL random_stall[%0d]: valid=%0b pc=%h data=%h required 1/%h/%h", c, inst_valid, inst_pc, inst_data, prev_pc, prev_data);
        end
      end
      prev_hold = inst_valid && !inst_ready;
      prev_pc   = inst_pc;
      prev_data = inst_data;
      next_cycle();
    end
    redirect_valid = 1'b0;
    n_cmp++;
    if (delivered - start < 200) begin
      n_err++;
      $display("FAIL random_progress: delivered=%0d required at least 200", delivered - start);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_async_reset();
    test_fetch_en();
    test_random();
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
